vc_read_scheduler: RTL
======================

// Module: vc_read_scheduler
// PURPOSE
// Per-input-port controller for the NUM_VC circular_buffer instances (one per VC).
// - Write side: gates upstream flit writes into the buffer selected by wr_vc_i.
// - Read side: picks one non-empty VC per cycle by round-robin, subject to downstream credits.
// - Returns one credit upstream for each flit read.
// - Drives only the buffers' write_i/read_i. Flit data moves buffer -> crossbar, outside this block.
// PARAMETERS
// NUM_VC    4                     number of virtual channels / buffers on this port
// VC_DEPTH  4                     depth of each buffer; also initial downstream credits per VC
// VC_W      $clog2(NUM_VC)        width of a VC index
// CRED_W    $clog2(VC_DEPTH+1)    width of one credit counter
// PORTS
// clk               in   1            clock; all state updates on posedge
// rst_n             in   1            synchronous, active-low reset
// enable_i          in   1            1 = read grants allowed; 0 = hold (writes still accepted)
// wr_valid_i        in   1            upstream flit present this cycle
// wr_vc_i           in   VC_W         target VC of that flit
// vc_full_i         in   NUM_VC       is_full of each buffer
// vc_empty_i        in   NUM_VC       is_empty of each buffer
// wr_o              out  NUM_VC       one-hot write_i strobes to the buffers (combinational)
// rd_o              out  NUM_VC       one-hot read_i strobes to the buffers (combinational)
// out_valid_o       out  1            buffer data_o holds a new flit (registered)
// out_vc_o          out  VC_W         VC of that flit (registered)
// credit_in_valid_i in   1            downstream returns one credit
// credit_in_vc_i    in   VC_W         VC of the returned credit
// credit_out_valid_o out 1            credit returned upstream (registered)
// credit_out_vc_o   out  VC_W         VC of the upstream credit
// overflow_err_o    out  1            sticky: write attempted to a full buffer
// credit_err_o      out  1            sticky: downstream credit counter would exceed VC_DEPTH
// idle_o            out  1            all buffers empty and no out_valid_o pending
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - All credit counters = VC_DEPTH; rr_ptr = 0.
//   - out_valid_o, credit_out_valid_o, both error flags = 0; out_vc_o, credit_out_vc_o = 0.
//   - Reset overrides all same-cycle inputs.
//   - A grant issued in the reset cycle is not recorded.
// - Write path:
//   - wr_o[v] = wr_valid_i & (wr_vc_i==v) & ~vc_full_i[v].
//   - Writes to a full buffer are dropped, even with a same-cycle read of that buffer.
//   - A dropped write sets overflow_err_o at the next edge; it clears only on reset.
// - Read eligibility: elig[v] = enable_i & ~vc_empty_i[v] & (cred[v] != 0).
// - Arbitration:
//   - Search elig from index rr_ptr upward, modulo NUM_VC; the first hit g gets rd_o[g]=1.
//   - At most one rd_o bit is set per cycle; rd_o = 0 if nothing is eligible.
//   - On a grant: rr_ptr <= (g==NUM_VC-1) ? 0 : g+1. With no grant, rr_ptr holds.
// - Output timing (latency 1, aligned with the buffer's registered data_o):
//   - The edge after a grant: out_valid_o=1, out_vc_o=g, credit_out_valid_o=1, credit_out_vc_o=g.
//   - Otherwise both valids = 0 and both VC outputs hold their last value.
// - Credit counter per VC v (width CRED_W, at each edge):
//   - Grant to v only: cred[v]-1.
//   - Credit return to v only: cred[v]+1.
//   - Grant and credit return to v in the same cycle: unchanged.
//   - Credit return that would exceed VC_DEPTH: saturate at VC_DEPTH and set credit_err_o (sticky).
//   - A grant never fires when cred[v]==0, so counters never underflow.
// - enable_i=0: no grants, credits and rr_ptr frozen apart from returns; an out_valid_o already registered still appears.
// - idle_o = &vc_empty_i & ~out_valid_o (combinational).
// - Reset mid-packet: buffers are reset by their own reset; this block discards any in-flight grant.
// TESTING
// - Reset, then 1 write to VC2, enable_i=1 -> rd_o=4'b0100 next cycle; out_valid_o=1, out_vc_o=2 one cycle later.
// - All 4 VCs non-empty, credits full -> grants 0,1,2,3,0 on consecutive cycles; rr_ptr wraps 3->0.
// - VC1 gets 4 grants with no credit return -> cred[1]=0 and VC1 skipped; one credit return to VC1 -> VC1 granted again.
// - Same-cycle grant and credit return on VC0 with cred[0]=2 -> cred[0] stays 2; return with cred=VC_DEPTH -> credit_err_o=1.
// - wr_valid_i to VC3 while vc_full_i[3]=1 -> wr_o=0; overflow_err_o=1 next edge and stays 1 until reset.
// - rst_n=0 in the same cycle as a grant -> no out_valid_o afterwards; all cred=VC_DEPTH, rr_ptr=0.

Source files
------------

// File: rtl/vc_read_scheduler.sv
// Per-input-port VC controller: gates upstream writes into the per-VC
// buffers, picks one non-empty VC per cycle by round-robin subject to
// downstream credits, and returns one credit upstream per flit read.
//
// Handshake: wr_o/rd_o are single-cycle strobes; the buffer acts on them
// at the same posedge. out_valid_o/credit_out_valid_o are one-cycle pulses
// with no back-pressure, aligned with the buffer's registered data_o.
module vc_read_scheduler #(
  parameter int NUM_VC   = 4,
  parameter int VC_DEPTH = 4,
  parameter int VC_W     = $clog2(NUM_VC),
  parameter int CRED_W   = $clog2(VC_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              wr_valid_i,
  input  logic [VC_W-1:0]   wr_vc_i,
  input  logic [NUM_VC-1:0] vc_full_i,
  input  logic [NUM_VC-1:0] vc_empty_i,
  output logic [NUM_VC-1:0] wr_o,
  output logic [NUM_VC-1:0] rd_o,
  output logic              out_valid_o,
  output logic [VC_W-1:0]   out_vc_o,
  input  logic              credit_in_valid_i,
  input  logic [VC_W-1:0]   credit_in_vc_i,
  output logic              credit_out_valid_o,
  output logic [VC_W-1:0]   credit_out_vc_o,
  output logic              overflow_err_o,
  output logic              credit_err_o,
  output logic              idle_o
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_DEPTH);
  localparam logic [VC_W:0]     NUM_VC_W = (VC_W+1)'(NUM_VC);

  logic [CRED_W-1:0] cred_q [NUM_VC];
  logic [CRED_W-1:0] cred_d [NUM_VC];
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [VC_W-1:0]   out_vc_q, out_vc_d;
  logic              overflow_err_q, overflow_err_d;
  logic              credit_err_q, credit_err_d;

  logic [NUM_VC-1:0] wr_req;
  logic [NUM_VC-1:0] ret_oh;
  logic [NUM_VC-1:0] elig;
  logic              grant_found;
  logic [VC_W-1:0]   grant_vc;
  logic [VC_W:0]     arb_sum;
  logic [VC_W-1:0]   arb_idx;

  // Decode write requests, credit returns and read eligibility per VC.
  always_comb begin
    wr_req = '0;
    ret_oh = '0;
    elig   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_req[v] = wr_valid_i & (wr_vc_i == VC_W'(v));
      ret_oh[v] = credit_in_valid_i & (credit_in_vc_i == VC_W'(v));
      elig[v]   = enable_i & ~vc_empty_i[v] & (cred_q[v] != '0);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible VC wins.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = '0;
    arb_sum     = '0;
    arb_idx     = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + (VC_W+1)'(i);
      if (arb_sum >= NUM_VC_W) arb_sum = arb_sum - NUM_VC_W;
      arb_idx = arb_sum[VC_W-1:0];
      if (!grant_found && elig[arb_idx]) begin
        grant_found = 1'b1;
        grant_vc    = arb_idx;
      end
    end
  end

  // Strobes to the buffers; full buffers never see a write strobe.
  always_comb begin
    wr_o = wr_req & ~vc_full_i;
    rd_o = grant_found ? (NUM_VC'(1) << grant_vc) : '0;
  end

  // Next-state for pointer, output registers, credits and sticky errors.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    out_valid_d    = grant_found;
    out_vc_d       = out_vc_q;
    overflow_err_d = overflow_err_q | (|(wr_req & vc_full_i));
    credit_err_d   = credit_err_q;
    cred_d         = cred_q;
    if (grant_found) begin
      rr_ptr_d = (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + 1'b1;
      out_vc_d = grant_vc;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      // A grant and a return on the same VC cancel out.
      if (ret_oh[v] && !rd_o[v]) begin
        if (cred_q[v] == CRED_MAX) credit_err_d = 1'b1;
        else                       cred_d[v]    = cred_q[v] + 1'b1;
      end else if (rd_o[v] && !ret_oh[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end
    end
  end

  // State registers; reset discards any grant issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_vc_q       <= '0;
      overflow_err_q <= 1'b0;
      credit_err_q   <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CRED_MAX;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_vc_q       <= out_vc_d;
      overflow_err_q <= overflow_err_d;
      credit_err_q   <= credit_err_d;
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= cred_d[v];
    end
  end

  // Data and upstream credit leave together, so they share one register.
  always_comb begin
    out_valid_o        = out_valid_q;
    out_vc_o           = out_vc_q;
    credit_out_valid_o = out_valid_q;
    credit_out_vc_o    = out_vc_q;
    overflow_err_o     = overflow_err_q;
    credit_err_o       = credit_err_q;
    idle_o             = (&vc_empty_i) & ~out_valid_q;
  end

endmodule
